// File: rtl/counter_pkg.sv
// counter_pkg: shared constants for the parametrised up/down counter.
// Provides direction / overflow-mode encodings and default widths used by
// counter_param, counter_next_calc and counter_param_if.
package counter_pkg;

  // Direction encoding for the dir input.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Overflow handling encoding for the sat_mode input.
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Default widths.
  localparam int CNT_WIDTH_DEF  = 16;
  localparam int STEP_WIDTH_DEF = 5;

endpackage : counter_pkg

// File: rtl/counter_param_if.sv
// counter_param_if: control/status bundle between the board controls and the
// counter. Controls: enable, load, load_value, dir, step, limit, sat_mode,
// disp. Status: count (live), output_value (display), tc (terminal count).
// master = control source / display driver side, slave = counter side.
interface counter_param_if #(
  parameter int WIDTH  = counter_pkg::CNT_WIDTH_DEF,
  parameter int STEP_W = counter_pkg::STEP_WIDTH_DEF
);

  logic              enable;
  logic              load;
  logic [WIDTH-1:0]  load_value;
  logic              dir;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  limit;
  logic              sat_mode;
  logic              disp;
  logic [WIDTH-1:0]  count;
  logic [WIDTH-1:0]  output_value;
  logic              tc;

  modport master (
    output enable, load, load_value, dir, step, limit, sat_mode, disp,
    input  count, output_value, tc
  );

  modport slave (
    input  enable, load, load_value, dir, step, limit, sat_mode, disp,
    output count, output_value, tc
  );

endinterface : counter_param_if

// File: rtl/counter_next_calc.sv
// counter_next_calc: purely combinational next-count calculation.
// Inputs: count_i (current), s_i (effective step, already clipped to limit),
//   limit_i, dir_i, sat_mode_i. Outputs: next_count_o, boundary_o (tc source).
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] s_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             dir_i,
  input  logic             sat_mode_i,
  output logic [WIDTH-1:0] next_count_o,
  output logic             boundary_o
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH:0]   sum_x;
  logic             up_over;
  logic             dn_under;
  logic             out_of_range;
  logic [WIDTH-1:0] wrap_up;
  logic [WIDTH-1:0] wrap_dn;

  // One extra bit so count + s can never lose its carry, even when
  // limit is all ones.
  assign sum_x        = {1'b0, count_i} + {1'b0, s_i};
  assign up_over      = sum_x > {1'b0, limit_i};
  assign dn_under     = count_i < s_i;
  assign out_of_range = count_i > limit_i;

  // The wrapped results always land in 0..limit, so plain modulo-2^WIDTH
  // arithmetic gives them exactly; intermediate overflow cancels out.
  // This also makes limit = all ones degenerate to ordinary modulo counting.
  assign wrap_up = count_i + s_i - limit_i - ONE;
  assign wrap_dn = count_i - s_i + limit_i + ONE;

  always_comb begin
    next_count_o = count_i;
    boundary_o   = 1'b0;

    if (out_of_range) begin
      // limit was lowered under the current count: snap back into range.
      // Checked before the zero-step case so a count can never stay stuck
      // above limit (e.g. limit = 0 forces s = 0).
      boundary_o   = 1'b1;
      next_count_o = (dir_i == DIR_UP && sat_mode_i == MODE_WRAP) ? ZERO : limit_i;
    end else if (s_i == ZERO) begin
      next_count_o = count_i;
    end else if (dir_i == DIR_UP) begin
      if (!up_over) begin
        next_count_o = sum_x[WIDTH-1:0];
      end else if (sat_mode_i == MODE_SAT) begin
        // Already pinned at limit: no new boundary event.
        if (count_i != limit_i) begin
          next_count_o = limit_i;
          boundary_o   = 1'b1;
        end
      end else begin
        next_count_o = wrap_up;
        boundary_o   = 1'b1;
      end
    end else begin
      if (!dn_under) begin
        next_count_o = count_i - s_i;
      end else if (sat_mode_i == MODE_SAT) begin
        // Already pinned at zero: no new boundary event.
        if (count_i != ZERO) begin
          next_count_o = ZERO;
          boundary_o   = 1'b1;
        end
      end else begin
        next_count_o = wrap_dn;
        boundary_o   = 1'b1;
      end
    end
  end

endmodule : counter_next_calc

// File: rtl/counter_param.sv
// counter_param: parametrised up/down modulus counter with wrap/saturate,
// synchronous load, registered terminal-count pulse and display-hold register.
// Ports: clock, clear (async active-high), bus (counter_param_if.slave):
//   controls enable/load/load_value/dir/step/limit/sat_mode/disp,
//   status count/output_value/tc. All state updates on the rising edge.
module counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH  = CNT_WIDTH_DEF,
  parameter int STEP_W = STEP_WIDTH_DEF
) (
  input  logic             clock,
  input  logic             clear,
  counter_param_if.slave   bus
);

  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] disp_q,   disp_d;
  logic             tc_q,     tc_d;

  logic [WIDTH-1:0] step_ext;
  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] load_clip;
  logic [WIDTH-1:0] calc_next;
  logic             calc_bnd;

  // Step is unsigned and zero-extended; a step larger than the whole
  // range is clipped to limit so a single move never skips more than
  // one full turn.
  assign step_ext  = WIDTH'(bus.step);
  assign s_eff     = (step_ext > bus.limit) ? bus.limit : step_ext;
  assign load_clip = (bus.load_value > bus.limit) ? bus.limit : bus.load_value;

  counter_next_calc #(
    .WIDTH (WIDTH)
  ) u_next_calc (
    .count_i      (count_q),
    .s_i          (s_eff),
    .limit_i      (bus.limit),
    .dir_i        (bus.dir),
    .sat_mode_i   (bus.sat_mode),
    .next_count_o (calc_next),
    .boundary_o   (calc_bnd)
  );

  // load beats enable; tc is a one-cycle pulse so it drops whenever no
  // boundary event happens this edge.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      count_d = load_clip;
    end else if (bus.enable) begin
      count_d = calc_next;
      tc_d    = calc_bnd;
    end
  end

  // Display follows the value count takes at this same edge, so a load
  // or count step shows up on the display without an extra cycle.
  assign disp_d = bus.disp ? count_d : disp_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count_q <= '0;
      disp_q  <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      disp_q  <= disp_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.count        = count_q;
  assign bus.output_value = disp_q;
  assign bus.tc           = tc_q;

endmodule : counter_param
